// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: elastic pipeline-stage register with a one-entry skid
// buffer. It carries a DATA_W data bundle and a CTRL_W control bundle and
// sustains one item per cycle under a valid/ready handshake. A synchronous
// flush empties the stage and forces the control fields to CTRL_RST.
// Optional feature macro: PIPE_PERF_CNT_EN adds saturating stall and bubble
// counters (ports stall_cnt, bubble_cnt).
module pipe_stage_elastic #(
  parameter int                DATA_W   = 256,
  parameter int                CTRL_W   = 16,
  parameter logic [CTRL_W-1:0] CTRL_RST = '0,
  parameter int                CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  // Occupancy encoding {skid_v, main_v}; 2'b10 cannot occur.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_FULL  = 2'b01;
  localparam logic [1:0] ST_SKID  = 2'b11;

  logic              main_v_q, main_v_d;
  logic [DATA_W-1:0] main_d_q, main_d_d;
  logic [CTRL_W-1:0] main_c_q, main_c_d;
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] skid_d_q, skid_d_d;
  logic [CTRL_W-1:0] skid_c_q, skid_c_d;

  logic [1:0] state;
  logic       in_fire;
  logic       out_fire;

  // Ready comes straight from the skid flop, so out_ready never reaches in_ready.
  assign in_ready  = ~skid_v_q;
  assign out_valid = main_v_q;
  assign out_data  = main_d_q;
  assign out_ctrl  = main_v_q ? main_c_q : CTRL_RST;

  assign in_fire  = in_valid & ~skid_v_q;
  assign out_fire = main_v_q & out_ready;
  assign state    = {skid_v_q, main_v_q};

  // Next-state for both entries; flush overrides every handshake event.
  always_comb begin
    main_v_d = main_v_q;
    main_d_d = main_d_q;
    main_c_d = main_c_q;
    skid_v_d = skid_v_q;
    skid_d_d = skid_d_q;
    skid_c_d = skid_c_q;
    if (flush) begin
      // Any in_fire this cycle is dropped; data registers keep stale values.
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
      main_c_d = CTRL_RST;
      skid_c_d = CTRL_RST;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            main_v_d = 1'b1;
            main_d_d = in_data;
            main_c_d = in_ctrl;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            main_d_d = in_data;
            main_c_d = in_ctrl;
          end else if (out_fire) begin
            main_v_d = 1'b0;
          end else if (in_fire) begin
            skid_v_d = 1'b1;
            skid_d_d = in_data;
            skid_c_d = in_ctrl;
          end
        end
        ST_SKID: begin
          // Skid drains into main before anything new is accepted (FIFO order).
          if (out_fire) begin
            main_d_d = skid_d_q;
            main_c_d = skid_c_q;
            skid_v_d = 1'b0;
            skid_c_d = CTRL_RST;
          end
        end
        default: begin
          main_v_d = 1'b0;
          skid_v_d = 1'b0;
          main_c_d = CTRL_RST;
          skid_c_d = CTRL_RST;
        end
      endcase
    end
  end

  // Main and skid registers; reset discards both entries immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v_q <= 1'b0;
      main_d_q <= '0;
      main_c_q <= CTRL_RST;
      skid_v_q <= 1'b0;
      skid_d_q <= '0;
      skid_c_q <= CTRL_RST;
    end else begin
      main_v_q <= main_v_d;
      main_d_q <= main_d_d;
      main_c_q <= main_c_d;
      skid_v_q <= skid_v_d;
      skid_d_q <= skid_d_d;
      skid_c_q <= skid_c_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;

  // Saturating counters: stall = held item refused, bubble = ready but empty.
  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (main_v_q && !out_ready && !(&stall_q))  stall_d  = stall_q + 1'b1;
    if (!main_v_q && out_ready && !(&bubble_q)) bubble_d = bubble_q + 1'b1;
  end

  // Counter registers; cleared only by reset, flush leaves them alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  logic [31:0] unused_cnt_w;
  assign unused_cnt_w = 32'(CNT_W);
`endif

endmodule
